sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares one asynchronous word SRAM (cs/oe/we/addr/din/dout interface, combinational read) between the instruction-fetch port and the load/store data port of the processor.
- Arbitrates round-robin between the two ports and sequences each access over a programmable number of wait cycles.
- Returns read data or a write completion to the winning port with a one-cycle ack pulse.
- Rejects misaligned word addresses without touching the SRAM.

Parameters:
ACCESS_CYCLES, 1, cycles the SRAM controls are held per access (1..15); dout sampled at end of last one
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
i_req  in  1  fetch request; held with stable i_addr until i_ack
i_addr  in  ADDR_W  fetch byte address
i_ack  out  1  one-cycle completion pulse for fetch
i_rdata  out  DATA_W  fetch data, valid while i_ack=1
i_err  out  1  misaligned fetch, valid while i_ack=1
d_req  in  1  data request; held with stable d_we/d_addr/d_wdata until d_ack
d_we  in  1  1=store, 0=load
d_addr  in  ADDR_W  data byte address
d_wdata  in  DATA_W  store data
d_ack  out  1  one-cycle completion pulse for data port
d_rdata  out  DATA_W  load data, valid while d_ack=1 and d_we=0
d_err  out  1  misaligned data access, valid while d_ack=1
sram_cs  out  1  SRAM chip select
sram_oe  out  1  SRAM output enable (reads)
sram_we  out  1  SRAM write enable (stores)
sram_addr  out  ADDR_W  SRAM address
sram_din  out  DATA_W  SRAM write data
sram_dout  in  DATA_W  SRAM read data (combinational from sram_addr)
busy  out  1  FSM not IDLE

Behaviour:
- Clocking: single clock domain; reset is synchronous and active-high. All outputs are registered.
- Reset values: every output is 0; state=IDLE; wait counter=0; last_grant=DATA, so the first tie goes to fetch.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Samples i_req and d_req at the clock edge.
  - If neither is asserted, stay in IDLE.
  - If only one is asserted, grant it.
  - If both are asserted, grant the port other than last_grant, then update last_grant.
  - Latch the grant id, we (always 0 for fetch), addr, and wdata into internal registers.
  - If latched addr[1:0]!=0, go to RESP with err=1, rdata=0, and no SRAM activity.
  - Otherwise go to ACCESS with counter=ACCESS_CYCLES-1.
- ACCESS:
  - sram_cs=1, sram_addr and sram_din held from the latch.
  - Read: sram_oe=1 for every ACCESS cycle, sram_we=0.
  - Write: sram_oe=0; sram_we=1 only in the first ACCESS cycle, then 0, giving exactly one write edge per store.
  - Counter decrements each cycle. At counter==0, capture sram_dout into the rdata register (reads only) and go to RESP.
- RESP:
  - SRAM controls: sram_cs/oe/we=0; sram_addr and sram_din keep the last value.
  - Ack: the granted port's ack=1 for exactly one cycle, with rdata and err valid. Then go to IDLE.
  - rdata is 0 for stores.
- Latency: req sampled at edge E. Ack is high in cycle E+ACCESS_CYCLES+1 for an aligned access, or E+1 for a misaligned one.
  - Requester sees ack at the next edge and deasserts or replaces req.
  - IDLE always re-samples req one cycle after RESP, so a stale req is never double-served.
- Back-to-back: a continuously requesting port with the other idle is served every ACCESS_CYCLES+2 cycles. Under contention, grants strictly alternate.
- Non-granted ack/rdata/err hold 0. The losing port's req is ignored until the next IDLE.
- Reset mid-access: at the next edge all outputs are 0 and state=IDLE. The in-flight request is dropped (no ack). A store whose first ACCESS cycle has already occurred has written the SRAM.
- Counter width: 4 bits.

Decomposition:
- Package sram_arb_pkg holds:
  - state enum (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2)
  - port id constants (PORT_I=1'b0, PORT_D=1'b1)
  - CNT_W=4
- One sub-module, rr_arb2: a combinational 2-way round-robin pick from {i_req, d_req, last_grant}. It is instantiated in IDLE decode and unit-testable on its own.

Test Plan:
- ACCESS_CYCLES=1, SRAM preloaded 0x00000010=0xDEADBEEF; i_req with i_addr=0x10 -> sram_cs=1, oe=1 for 1 cycle; i_ack pulse 2 cycles after the req edge with i_rdata=0xDEADBEEF; i_err=0.
- d_req, d_we=1, d_addr=0x20, d_wdata=0x12345678, then a load of 0x20 -> sram_we high exactly 1 cycle; later d_rdata=0x12345678.
- i_req and d_req both held continuously after reset -> grant order I, D, I, D; each ack separated by ACCESS_CYCLES+2 cycles; no port acked twice in a row.
- d_req with d_addr=0x22 -> d_ack with d_err=1, d_rdata=0 one cycle after the req edge; sram_cs never asserted.
- ACCESS_CYCLES=3, load 0x10 -> sram_cs/oe high for 3 cycles; ack at E+4 with correct data.
- reset asserted during the second ACCESS cycle of a load -> all outputs 0 next edge; no i_ack/d_ack; a new request afterwards completes normally.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM port arbiter.
package sram_arb_pkg;
  localparam int CNT_W = 4;
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;
endpackage

// File: rtl/sram_port_arbiter_rr_arb2.sv
// Two-way round-robin pick between fetch and data requests.
module rr_arb2
  import sram_arb_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
  input  logic last_grant,
  output logic valid,
  output logic grant
);
  always_comb begin
    valid = i_req | d_req;
    grant = PORT_I;
    unique case (1'b1)
      (i_req && d_req):  grant = ~last_grant;
      (d_req && !i_req): grant = PORT_D;
      default:           grant = PORT_I;
    endcase
  end
endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one async word SRAM between fetch and load/store ports,
// round-robin, with a programmable number of access cycles.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ACCESS_CYCLES = 1,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              sram_cs,
  output logic              sram_oe,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  input  logic [DATA_W-1:0] sram_dout,
  output logic              busy
);
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             last_grant;
  logic             port;
  logic             wr;
  logic             gnt_valid;
  logic             gnt;
  logic             sel_we;
  logic [ADDR_W-1:0] sel_addr;

  rr_arb2 u_arb (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_grant (last_grant),
    .valid      (gnt_valid),
    .grant      (gnt)
  );

  always_comb begin
    sel_we   = (gnt == PORT_D) && d_we;
    sel_addr = (gnt == PORT_D) ? d_addr : i_addr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= PORT_D;
      port       <= PORT_I;
      wr         <= 1'b0;
      i_ack      <= 1'b0;
      i_rdata    <= '0;
      i_err      <= 1'b0;
      d_ack      <= 1'b0;
      d_rdata    <= '0;
      d_err      <= 1'b0;
      sram_cs    <= 1'b0;
      sram_oe    <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_din   <= '0;
      busy       <= 1'b0;
    end else begin
      i_ack   <= 1'b0;
      i_rdata <= '0;
      i_err   <= 1'b0;
      d_ack   <= 1'b0;
      d_rdata <= '0;
      d_err   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (gnt_valid) begin
            last_grant <= gnt;
            port       <= gnt;
            wr         <= sel_we;
            busy       <= 1'b1;
            if (sel_addr[1:0] != 2'b00) begin
              // misaligned: answer at once, SRAM untouched
              state <= RESP;
              i_ack <= (gnt == PORT_I);
              i_err <= (gnt == PORT_I);
              d_ack <= (gnt == PORT_D);
              d_err <= (gnt == PORT_D);
            end else begin
              state     <= ACCESS;
              cnt       <= CNT_W'(ACCESS_CYCLES - 1);
              sram_cs   <= 1'b1;
              sram_oe   <= !sel_we;
              sram_we   <= sel_we;
              sram_addr <= sel_addr;
              if (sel_we)
                sram_din <= d_wdata;
            end
          end
        end
        ACCESS: begin
          // one write strobe per store
          sram_we <= 1'b0;
          if (cnt == '0) begin
            state   <= RESP;
            sram_cs <= 1'b0;
            sram_oe <= 1'b0;
            i_ack   <= (port == PORT_I);
            d_ack   <= (port == PORT_D);
            if (!wr && port == PORT_I)
              i_rdata <= sram_dout;
            if (!wr && port == PORT_D)
              d_rdata <= sram_dout;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench: two arbiters (1 and 3 access cycles) on SRAM models.
module tb_sram_port_arbiter;
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset [2];
  logic        i_req [2];
  logic [31:0] i_addr [2];
  logic        i_ack [2];
  logic [31:0] i_rdata [2];
  logic        i_err [2];
  logic        d_req [2];
  logic        d_we [2];
  logic [31:0] d_addr [2];
  logic [31:0] d_wdata [2];
  logic        d_ack [2];
  logic [31:0] d_rdata [2];
  logic        d_err [2];
  logic        sram_cs [2];
  logic        sram_oe [2];
  logic        sram_we [2];
  logic [31:0] sram_addr [2];
  logic [31:0] sram_din [2];
  logic [31:0] sram_dout [2];
  logic        busy [2];

  logic [31:0] mem [2][256];
  logic        preload;
  exp_t        q [4][$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  sram_port_arbiter #(.ACCESS_CYCLES(1)) u0 (
    .clk(clk), .reset(reset[0]),
    .i_req(i_req[0]), .i_addr(i_addr[0]), .i_ack(i_ack[0]),
    .i_rdata(i_rdata[0]), .i_err(i_err[0]),
    .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]),
    .d_wdata(d_wdata[0]), .d_ack(d_ack[0]),
    .d_rdata(d_rdata[0]), .d_err(d_err[0]),
    .sram_cs(sram_cs[0]), .sram_oe(sram_oe[0]), .sram_we(sram_we[0]),
    .sram_addr(sram_addr[0]), .sram_din(sram_din[0]),
    .sram_dout(sram_dout[0]), .busy(busy[0])
  );

  sram_port_arbiter #(.ACCESS_CYCLES(3)) u1 (
    .clk(clk), .reset(reset[1]),
    .i_req(i_req[1]), .i_addr(i_addr[1]), .i_ack(i_ack[1]),
    .i_rdata(i_rdata[1]), .i_err(i_err[1]),
    .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]),
    .d_wdata(d_wdata[1]), .d_ack(d_ack[1]),
    .d_rdata(d_rdata[1]), .d_err(d_err[1]),
    .sram_cs(sram_cs[1]), .sram_oe(sram_oe[1]), .sram_we(sram_we[1]),
    .sram_addr(sram_addr[1]), .sram_din(sram_din[1]),
    .sram_dout(sram_dout[1]), .busy(busy[1])
  );

  assign sram_dout[0] = mem[0][sram_addr[0][9:2]];
  assign sram_dout[1] = mem[1][sram_addr[1][9:2]];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (preload) begin
        mem[k][4] <= 32'hDEADBEEF;
        mem[k][8] <= (k == 0) ? 32'h0 : 32'hCAFEF00D;
      end else if (sram_cs[k] && sram_we[k]) begin
        mem[k][sram_addr[k][9:2]] <= sram_din[k];
      end
    end
  end

  function automatic void chk_ack(int k, int p, logic [31:0] rd, logic er);
    exp_t e;
    checks++;
    if (q[2*k+p].size() == 0) begin
      errors++;
      $display("FAIL unexpected_ack inst%0d port%0d cyc=%0d", k, p, cyc);
      return;
    end
    e = q[2*k+p].pop_front();
    if (rd !== e.rdata || er !== e.err || cyc != e.cyc) begin
      errors++;
      $display("FAIL ack inst%0d port%0d got rdata=%h err=%b cyc=%0d want rdata=%h err=%b cyc=%0d",
               k, p, rd, er, cyc, e.rdata, e.err, e.cyc);
    end
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (i_ack[k] === 1'b1) chk_ack(k, 0, i_rdata[k], i_err[k]);
      if (d_ack[k] === 1'b1) chk_ack(k, 1, d_rdata[k], d_err[k]);
    end
  end

  function automatic void push(int k, int p, logic [31:0] rd, logic er, int c);
    exp_t e;
    e.rdata = rd;
    e.err = er;
    e.cyc = c;
    q[2*k+p].push_back(e);
  endfunction

  function automatic void chk_zero(int k, string name);
    logic any;
    any = i_ack[k] | d_ack[k] | i_err[k] | d_err[k] | busy[k]
        | sram_cs[k] | sram_oe[k] | sram_we[k]
        | (|i_rdata[k]) | (|d_rdata[k]) | (|sram_addr[k]) | (|sram_din[k]);
    checks++;
    if (any !== 1'b0) begin
      errors++;
      $display("FAIL %s inst%0d outputs not all zero: cs=%b ack=%b/%b busy=%b addr=%h",
               name, k, sram_cs[k], i_ack[k], d_ack[k], busy[k], sram_addr[k]);
    end
  endfunction

  // Called at a negedge; leaves reset deasserted for the next edge.
  task automatic do_reset(int k, string name);
    reset[k] = 1'b1;
    @(negedge clk);
    chk_zero(k, name);
    reset[k] = 1'b0;
  endtask

  task automatic access(int k, int p, logic we, logic [31:0] a,
                        logic [31:0] wd, logic [31:0] exp_rd, logic er);
    int ac;
    int ncs;
    int noe;
    int nwe;
    logic al;
    logic got;
    ac = (k == 0) ? 1 : 3;
    al = (a[1:0] == 2'b00);
    ncs = 0; noe = 0; nwe = 0; got = 1'b0;
    @(negedge clk);
    push(k, p, exp_rd, er, cyc + 1 + (al ? ac : 0));
    if (p == 0) begin
      i_req[k] = 1'b1; i_addr[k] = a;
    end else begin
      d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = a; d_wdata[k] = wd;
    end
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (sram_cs[k]) ncs++;
      if (sram_oe[k]) noe++;
      if (sram_we[k]) nwe++;
      got = (p == 0) ? i_ack[k] : d_ack[k];
    end
    i_req[k] = 1'b0;
    d_req[k] = 1'b0;
    checks += 4;
    if (!got) begin
      errors++;
      $display("FAIL ack_timeout inst%0d port%0d addr=%h", k, p, a);
    end
    if (ncs != (al ? ac : 0)) begin
      errors++;
      $display("FAIL cs_cycles inst%0d addr=%h got %0d want %0d", k, a, ncs, al ? ac : 0);
    end
    if (nwe != ((al && we) ? 1 : 0)) begin
      errors++;
      $display("FAIL we_cycles inst%0d addr=%h got %0d want %0d", k, a, nwe, (al && we) ? 1 : 0);
    end
    if (noe != ((al && !we) ? ac : 0)) begin
      errors++;
      $display("FAIL oe_cycles inst%0d addr=%h got %0d want %0d", k, a, noe, (al && !we) ? ac : 0);
    end
  endtask

  initial begin
    int base;
    int nd;
    for (int k = 0; k < 2; k++) begin
      reset[k] = 1'b1;
      i_req[k] = 1'b0; i_addr[k] = '0;
      d_req[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0;
    end
    preload = 1'b1;
    @(negedge clk);
    @(negedge clk);
    preload = 1'b0;
    chk_zero(0, "reset_state");
    chk_zero(1, "reset_state");
    reset[0] = 1'b0;
    reset[1] = 1'b0;

    access(0, 0, 1'b0, 32'h10, '0, 32'hDEADBEEF, 1'b0);
    access(0, 1, 1'b1, 32'h20, 32'h12345678, 32'h0, 1'b0);
    access(0, 1, 1'b0, 32'h20, '0, 32'h12345678, 1'b0);
    access(0, 1, 1'b0, 32'h22, '0, 32'h0, 1'b1);
    access(0, 0, 1'b0, 32'h13, '0, 32'h0, 1'b1);

    // contention straight after reset: fetch wins first, then alternate
    @(negedge clk);
    do_reset(0, "reset_before_contention");
    base = cyc + 1;
    i_req[0] = 1'b1; i_addr[0] = 32'h10;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h20;
    push(0, 0, 32'hDEADBEEF, 1'b0, base + 1);
    push(0, 1, 32'h12345678, 1'b0, base + 4);
    push(0, 0, 32'hDEADBEEF, 1'b0, base + 7);
    push(0, 1, 32'h12345678, 1'b0, base + 10);
    nd = 0;
    for (int n = 0; n < 60 && nd < 2; n++) begin
      @(negedge clk);
      if (d_ack[0]) nd++;
    end
    i_req[0] = 1'b0;
    d_req[0] = 1'b0;
    checks++;
    if (nd != 2) begin
      errors++;
      $display("FAIL contention_timeout got %0d data acks want 2", nd);
    end

    access(1, 0, 1'b0, 32'h10, '0, 32'hDEADBEEF, 1'b0);

    // reset during the second ACCESS cycle of a load
    @(negedge clk);
    i_req[1] = 1'b1; i_addr[1] = 32'h10;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sram_cs[1] !== 1'b1) begin
      errors++;
      $display("FAIL mid_access_cs got %b want 1", sram_cs[1]);
    end
    do_reset(1, "reset_mid_access");
    i_req[1] = 1'b0;
    repeat (6) @(negedge clk);
    access(1, 1, 1'b0, 32'h20, '0, 32'hCAFEF00D, 1'b0);
    access(1, 1, 1'b1, 32'h24, 32'hA5A5_0001, 32'h0, 1'b0);
    access(1, 0, 1'b0, 32'h24, '0, 32'hA5A5_0001, 1'b0);

    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (q[i].size() != 0) begin
        errors++;
        $display("FAIL missing_ack queue%0d has %0d pending want 0", i, q[i].size());
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
